// File: rtl/core_wb_arb_if.sv
// Write-back arbiter bus: per-source result handshakes, flush, and the register-file write port.
// The master side drives results and flush; the slave side is the arbiter.
interface core_wb_arb_if #(
    parameter int unsigned NUM_SRC = 3,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned RFIDX_W = 5
);
    logic [NUM_SRC-1:0]         src_valid_i;
    logic [NUM_SRC-1:0]         src_ready_o;
    logic [NUM_SRC*RFIDX_W-1:0] src_rd_idx_i;
    logic [NUM_SRC*DATA_W-1:0]  src_data_i;
    logic                       flush_i;
    logic                       rf_we_o;
    logic [RFIDX_W-1:0]         rf_idx_o;
    logic [DATA_W-1:0]          rf_data_o;
    logic                       busy_o;

    modport master (
        output src_valid_i, src_rd_idx_i, src_data_i, flush_i,
        input  src_ready_o, rf_we_o, rf_idx_o, rf_data_o, busy_o
    );

    modport slave (
        input  src_valid_i, src_rd_idx_i, src_data_i, flush_i,
        output src_ready_o, rf_we_o, rf_idx_o, rf_data_o, busy_o
    );
endinterface

// File: rtl/core_wb_arb.sv
// Write-back arbiter: per-source result FIFOs drained round-robin into a single RF write port.
// Define WB_STALL_CNT_EN to add stall_cnt_o, a saturating count of cycles with >= 2 busy queues.
module core_wb_arb #(
    parameter int unsigned NUM_SRC    = 3,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned RFIDX_W    = 5,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    core_wb_arb_if.slave wb
`ifdef WB_STALL_CNT_EN
    ,
    output logic [31:0]  stall_cnt_o
`endif
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SrcW = $clog2(NUM_SRC);

    logic [RFIDX_W-1:0] idx_mem  [NUM_SRC][FIFO_DEPTH];
    logic [DATA_W-1:0]  data_mem [NUM_SRC][FIFO_DEPTH];
    logic [PtrW-1:0]    rd_ptr_q [NUM_SRC];
    logic [PtrW-1:0]    wr_ptr_q [NUM_SRC];
    logic [CntW-1:0]    cnt_q    [NUM_SRC];

    logic [NUM_SRC-1:0] empty;
    logic [NUM_SRC-1:0] full;
    logic [NUM_SRC-1:0] src_ready;
    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] pop;

    logic [SrcW-1:0]    rr_ptr_q;
    logic [SrcW-1:0]    rr_ptr_d;
    logic [SrcW-1:0]    cand;
    logic [SrcW-1:0]    gnt_idx;
    logic               gnt_vld;

    logic [RFIDX_W-1:0] head_idx;
    logic [DATA_W-1:0]  head_data;
    logic               rf_we_d;
    logic               rf_we_q;
    logic [RFIDX_W-1:0] rf_idx_q;
    logic [DATA_W-1:0]  rf_data_q;

    // Ready never looks at this cycle's pop, so a full queue cannot accept.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            empty[i] = (cnt_q[i] == '0);
            full[i]  = (cnt_q[i] == CntW'(FIFO_DEPTH));
        end
        src_ready = ~full & {NUM_SRC{~wb.flush_i}};
        push      = wb.src_valid_i & src_ready;
    end

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            cand = SrcW'((32'(rr_ptr_q) + k) % NUM_SRC);
            if (!gnt_vld && !empty[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
        if (wb.flush_i) begin
            gnt_vld = 1'b0;
        end
        pop = '0;
        if (gnt_vld) begin
            pop[gnt_idx] = 1'b1;
        end
        rr_ptr_d = rr_ptr_q;
        if (gnt_vld) begin
            rr_ptr_d = (gnt_idx == SrcW'(NUM_SRC - 1)) ? '0 : gnt_idx + SrcW'(1);
        end
    end

    assign head_idx  = idx_mem[gnt_idx][rd_ptr_q[gnt_idx]];
    assign head_data = data_mem[gnt_idx][rd_ptr_q[gnt_idx]];
    // Writes to x0 are consumed but never reach the register file.
    assign rf_we_d   = gnt_vld && (head_idx != '0);

    always_ff @(posedge clk) begin
        if (rst || wb.flush_i) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                rd_ptr_q[i] <= '0;
                wr_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (push[i]) begin
                    wr_ptr_q[i] <= wr_ptr_q[i] + PtrW'(1);
                end
                if (pop[i]) begin
                    rd_ptr_q[i] <= rd_ptr_q[i] + PtrW'(1);
                end
                case ({push[i], pop[i]})
                    2'b10:   cnt_q[i] <= cnt_q[i] + CntW'(1);
                    2'b01:   cnt_q[i] <= cnt_q[i] - CntW'(1);
                    default: cnt_q[i] <= cnt_q[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (push[i]) begin
                idx_mem[i][wr_ptr_q[i]]  <= wb.src_rd_idx_i[i*RFIDX_W +: RFIDX_W];
                data_mem[i][wr_ptr_q[i]] <= wb.src_data_i[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q  <= '0;
            rf_we_q   <= 1'b0;
            rf_idx_q  <= '0;
            rf_data_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            rf_we_q  <= rf_we_d;
            if (rf_we_d) begin
                rf_idx_q  <= head_idx;
                rf_data_q <= head_data;
            end
        end
    end

    assign wb.src_ready_o = src_ready;
    assign wb.rf_we_o     = rf_we_q;
    assign wb.rf_idx_o    = rf_idx_q;
    assign wb.rf_data_o   = rf_data_q;
    assign wb.busy_o      = !rst && ((~empty != '0) || rf_we_q);

`ifdef WB_STALL_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [2:0]  ne_cnt;

    always_comb begin
        ne_cnt = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            ne_cnt = ne_cnt + 3'(!empty[i]);
        end
    end

    // Flush does not clear this count; only reset does.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (ne_cnt >= 3'd2 && stall_cnt_q != '1) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif
endmodule
